// File: rtl/me_frame_server.sv
// Memory responder and job sequencer for the motion estimator core.
// Loads a reference block and a search window into on-chip RAMs, serves the
// core's three read ports, starts a job and holds its result until accepted.
module me_frame_server #(
  parameter int unsigned DW          = 8,
  parameter int unsigned RA_W        = 8,
  parameter int unsigned SA_W        = 10,
  parameter int unsigned TIMEOUT_CYC = 16384
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [DW-1:0]   load_data,
  input  logic [RA_W-1:0] AddressR,
  input  logic [SA_W-1:0] AddressS1,
  input  logic [SA_W-1:0] AddressS2,
  output logic [DW-1:0]   R,
  output logic [DW-1:0]   S1,
  output logic [DW-1:0]   S2,
  output logic            Start,
  input  logic            completed,
  input  logic [3:0]      motionX,
  input  logic [3:0]      motionY,
  input  logic [7:0]      BestDist,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [3:0]      res_mx,
  output logic [3:0]      res_my,
  output logic [7:0]      res_dist,
  output logic            res_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [SA_W-1:0] RefLast  = SA_W'((2 ** RA_W) - 1);
  localparam logic [SA_W-1:0] SrchLast = SA_W'((2 ** SA_W) - 1);
  localparam logic [TW-1:0]   TmoLast  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StLoadR, StLoadS, StStart, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [SA_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            comp_q, comp_d;
  logic            load_ready_q, load_ready_d;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      res_mx_q, res_mx_d;
  logic [3:0]      res_my_q, res_my_d;
  logic [7:0]      res_dist_q, res_dist_d;
  logic            res_timeout_q, res_timeout_d;
  logic [DW-1:0]   r_q, s1_q, s2_q;

  logic [DW-1:0] ref_mem  [2 ** RA_W];
  logic [DW-1:0] srch_mem [2 ** SA_W];

  logic accept, ref_we, srch_we, rise;

  assign accept  = load_valid & load_ready_q;
  assign ref_we  = accept & (state_q == StLoadR);
  assign srch_we = accept & (state_q == StLoadS);
  // comp_q follows completed every cycle, so a level already high when RUN
  // is entered (sampled in START) never looks like an edge.
  assign rise    = completed & ~comp_q;

  // Next-state, counters and result capture.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    res_valid_d   = res_valid_q;
    res_mx_d      = res_mx_q;
    res_my_d      = res_my_q;
    res_dist_d    = res_dist_q;
    res_timeout_d = res_timeout_q;
    comp_d        = completed;
    unique case (state_q)
      StLoadR: begin
        if (accept) begin
          if (wr_cnt_q == RefLast) begin
            wr_cnt_d = '0;
            state_d  = StLoadS;
          end else begin
            wr_cnt_d = wr_cnt_q + SA_W'(1);
          end
        end
      end
      StLoadS: begin
        if (accept) begin
          if (wr_cnt_q == SrchLast) begin
            wr_cnt_d = '0;
            state_d  = StStart;
          end else begin
            wr_cnt_d = wr_cnt_q + SA_W'(1);
          end
        end
      end
      StStart: begin
        tmo_cnt_d = '0;
        state_d   = StRun;
      end
      StRun: begin
        if (tmo_cnt_q != TmoLast) tmo_cnt_d = tmo_cnt_q + TW'(1);
        // Completion is checked first so it wins over a same-cycle timeout.
        if (rise) begin
          res_mx_d      = motionX;
          res_my_d      = motionY;
          res_dist_d    = BestDist;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = StDone;
        end else if (tmo_cnt_q == TmoLast) begin
          res_mx_d      = '0;
          res_my_d      = '0;
          res_dist_d    = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = StDone;
        end
      end
      StDone: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StLoadR;
        end
      end
      default: state_d = StLoadR;
    endcase
    load_ready_d = (state_d == StLoadR) || (state_d == StLoadS);
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StLoadR;
      wr_cnt_q      <= '0;
      tmo_cnt_q     <= '0;
      comp_q        <= 1'b0;
      load_ready_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_mx_q      <= '0;
      res_my_q      <= '0;
      res_dist_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      comp_q        <= comp_d;
      load_ready_q  <= load_ready_d;
      res_valid_q   <= res_valid_d;
      res_mx_q      <= res_mx_d;
      res_my_q      <= res_my_d;
      res_dist_q    <= res_dist_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // RAM writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ref_we)  ref_mem[wr_cnt_q[RA_W-1:0]] <= load_data;
    if (srch_we) srch_mem[wr_cnt_q]          <= load_data;
  end

  // Registered read ports; a same-cycle write returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      r_q  <= ref_mem[AddressR];
      s1_q <= srch_mem[AddressS1];
      s2_q <= srch_mem[AddressS2];
    end
  end

  assign load_ready  = load_ready_q;
  assign Start       = (state_q == StStart);
  assign R           = r_q;
  assign S1          = s1_q;
  assign S2          = s2_q;
  assign res_valid   = res_valid_q;
  assign res_mx      = res_mx_q;
  assign res_my      = res_my_q;
  assign res_dist    = res_dist_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_me_frame_server.sv
// Bench for me_frame_server: random load streams, reads checked against an
// array model, job results checked through a scoreboard queue.
module tb_me_frame_server;

  localparam int unsigned T = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_valid, load_ready, Start, completed, res_valid, res_ready, res_timeout;
  logic [7:0] load_data, AddressR, R, S1, S2, BestDist, res_dist;
  logic [9:0] AddressS1, AddressS2;
  logic [3:0] motionX, motionY, res_mx, res_my;

  me_frame_server #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .AddressR(AddressR), .AddressS1(AddressS1),
    .AddressS2(AddressS2), .R(R), .S1(S1), .S2(S2), .Start(Start),
    .completed(completed), .motionX(motionX), .motionY(motionY), .BestDist(BestDist),
    .res_valid(res_valid), .res_ready(res_ready), .res_mx(res_mx), .res_my(res_my),
    .res_dist(res_dist), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [7:0] r; logic [7:0] s1; logic [7:0] s2;} rd_t;
  typedef struct {logic [3:0] mx; logic [3:0] my; logic [7:0] d; logic to;} res_t;

  logic [7:0] ref_m  [256];
  logic [7:0] srch_m [1024];
  rd_t  rd_q[$];
  res_t res_exp[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ab;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Read monitor: compare data for addresses issued in an earlier cycle.
  always @(negedge clk) begin
    rd_t e;
    if (rst_n && rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
      e = rd_q.pop_front();
      chk("rd_data", 64'({R, S1, S2}), 64'({e.r, e.s1, e.s2}));
    end
  end

  // Result monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    res_t e;
    if (rst_n && res_valid && res_ready) begin
      if (res_exp.size() == 0) begin
        chk("res_unexpected", 64'(1), 64'(0));
      end else begin
        e = res_exp.pop_front();
        chk("res_data", 64'({res_mx, res_my, res_dist, res_timeout}),
            64'({e.mx, e.my, e.d, e.to}));
      end
    end
  end

  task automatic push_rd(input bit fixed);
    if (fixed) begin
      AddressR = 8'd0; AddressS1 = 10'd5; AddressS2 = 10'd1023;
    end else begin
      AddressR = 8'($urandom); AddressS1 = 10'($urandom); AddressS2 = 10'($urandom);
    end
    rd_q.push_back('{cyc, ref_m[AddressR], srch_m[AddressS1], srch_m[AddressS2]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_q.delete();
    res_exp.delete();
    load_valid = 1'b0; completed = 1'b0; res_ready = 1'b0;
    #1;
    chk("rst_outs", 64'({R, S1, S2, Start, load_ready, res_valid, res_mx, res_my, res_dist,
                         res_timeout}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rel_ready", 64'(load_ready), 64'(0));
    @(posedge clk);
    #1 chk("rst_first_edge_ready", 64'(load_ready), 64'(1));
  endtask

  // Stream 256 ref + 1024 search beats; optionally abort by reset at a beat.
  task automatic load_job(input bit rnd, input bit pat, input int abort_at, output bit aborted);
    int cnt = 0;
    int n = 0;
    bit v;
    logic [7:0] d;
    completed = 1'b0; res_ready = 1'b0; aborted = 1'b0;
    while (cnt < 1280 && n < 6000) begin
      @(posedge clk); #1;
      n++;
      if (abort_at >= 0 && cnt == abort_at) begin
        do_reset();
        aborted = 1'b1;
        return;
      end
      chk("ld_ctl", 64'({load_ready, Start}), 64'(2'b10));
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      d = pat ? (cnt < 256 ? 8'(cnt) : 8'((cnt - 256) * 3)) : 8'($urandom);
      load_valid = v;
      load_data  = d;
      if (v && load_ready) begin
        if (cnt < 256) ref_m[cnt] = d;
        else srch_m[cnt - 256] = d;
        cnt++;
      end
    end
    if (cnt < 1280) chk("ld_budget", 64'(cnt), 64'(1280));
  endtask

  // mode 0: completion at RUN cycle kc; 1: timeout, completed low;
  // 2: timeout, completed stuck high; 3: completion on the timeout cycle.
  task automatic run_job(input int mode, input int kc_in, input logic [3:0] mx,
                         input logic [3:0] my, input logic [7:0] dd, input int hold,
                         input int abort_k, input bit fixed);
    int k = 0;
    int kc = kc_in;
    int k_exp;
    bit got = 1'b0;
    res_t e;
    @(posedge clk); #1;
    chk("start_ctl", 64'({Start, load_ready}), 64'(2'b10));
    load_valid = 1'($urandom); load_data = 8'($urandom);
    completed = (mode == 2);
    push_rd(fixed);
    if (mode == 1 || mode == 2) begin
      e = '{4'd0, 4'd0, 8'd0, 1'b1};
      res_exp.push_back(e);
      k_exp = T;
    end else begin
      if (mode == 3) kc = T - 1;
      e = '{mx, my, dd, 1'b0};
      k_exp = kc + 1;
    end
    while (k <= T + 4) begin
      @(posedge clk); #1;
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      if (abort_k >= 0 && k == abort_k) begin
        do_reset();
        return;
      end
      chk("run_ctl", 64'({Start, load_ready}), 64'(0));
      load_valid = 1'($urandom); load_data = 8'($urandom);
      res_ready = 1'($urandom);
      push_rd(1'b0);
      motionX = 4'($urandom); motionY = 4'($urandom); BestDist = 8'($urandom);
      if (mode == 0 || mode == 3) begin
        completed = (k >= kc);
        if (k == kc) begin
          motionX = mx; motionY = my; BestDist = dd;
          res_exp.push_back(e);
        end
      end
      k++;
    end
    res_ready = 1'b0;
    chk("res_latency", 64'(got ? k : -1), 64'(k_exp));
    if (!got) return;
    for (int h = 0; h < hold; h++) begin
      chk("res_hold", 64'({res_valid, load_ready, res_mx, res_my, res_dist, res_timeout}),
          64'({1'b1, 1'b0, e.mx, e.my, e.d, e.to}));
      load_valid = 1'($urandom); load_data = 8'($urandom);
      push_rd(1'b0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    load_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b0;
    completed = 1'b0;
    chk("res_done", 64'({res_valid, load_ready}), 64'(2'b01));
  endtask

  initial begin
    load_valid = 1'b0; load_data = '0; completed = 1'b0; res_ready = 1'b0;
    AddressR = '0; AddressS1 = '0; AddressS2 = '0;
    motionX = '0; motionY = '0; BestDist = '0;
    #1 do_reset();
    // Pattern load, S1=5 -> 15, S2=1023 -> 0xFD, completion held 10 cycles.
    load_job(1'b0, 1'b1, -1, ab);
    run_job(0, 20, 4'd3, 4'd12, 8'h2A, 10, -1, 1'b1);
    load_job(1'b1, 1'b0, -1, ab);
    run_job(1, 0, 4'd0, 4'd0, 8'd0, 3, -1, 1'b0);
    load_job(1'b1, 1'b0, -1, ab);
    run_job(2, 0, 4'd0, 4'd0, 8'd0, 1 + int'($urandom_range(0, 4)), -1, 1'b0);
    load_job(1'b1, 1'b1, -1, ab);
    run_job(3, 0, 4'($urandom), 4'($urandom), 8'($urandom), 2, -1, 1'b0);
    // Reset mid search load, then mid RUN, then a clean job.
    load_job(1'b1, 1'b1, 500, ab);
    chk("abort_taken", 64'(ab), 64'(1));
    load_job(1'b0, 1'b1, -1, ab);
    run_job(0, int'($urandom_range(0, T - 2)), 4'($urandom), 4'($urandom), 8'($urandom),
            1, 40, 1'b0);
    load_job(1'b1, 1'b0, -1, ab);
    run_job(0, int'($urandom_range(0, T - 2)), 4'($urandom), 4'($urandom), 8'($urandom),
            2, -1, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("res_pending", 64'(res_exp.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
